axis_header_insert_stream: RTL and testbench

AXIS_HEADER_INSERT_STREAM -- requirements
Module: axis_header_insert_stream

---
 rtl/axis_header_insert_stream.sv | 204 ++++++++++++++++++++
 tb/tb_axis_header_insert_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_header_insert_stream.sv
// axis_header_insert_stream
// Prepends a 0..W byte header to an AXI-Stream packet. Payload bytes are
// realigned behind the header through a residual buffer. Byte 0 sits in the MSBs.
// Optional feature: define AXIS_HDR_STATS_EN to add a 16-bit pkt_cnt output
// that counts packets leaving the block.
module axis_header_insert_stream #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // payload stream
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   // output stream with header prepended
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   // header
   input  logic                    valid_insert,
   output logic                    ready_insert,
   input  logic [DATA_WD-1:0]      data_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   input  logic [BYTE_CNT_WD-1:0]  hdr_byte_cnt
`ifdef AXIS_HDR_STATS_EN
   ,
   output logic [15:0]             pkt_cnt
`endif
);

   localparam int W  = DATA_BYTE_WD;
   // One extra bit so residual + payload counts (up to 2W) never overflow
   localparam int CW = BYTE_CNT_WD + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BODY  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_WD-1:0]   res_q, res_d;     // residual bytes, left-justified, unused bytes zero
   logic [CW-1:0]        r_q, r_d;         // number of valid residual bytes
   logic [DATA_WD-1:0]   data_q, data_d;
   logic [W-1:0]         keep_q, keep_d;
   logic                 last_q, last_d;
   logic                 valid_q, valid_d;

   logic                 out_free;
   logic [DATA_WD-1:0]   payload_masked;
   logic [2*DATA_WD-1:0] merged;
   logic [CW-1:0]        k_cnt;
   logic [CW-1:0]        t_cnt;
   logic [CW-1:0]        hdr_n;
   logic                 unused_keep_insert;

   // Header byte enables carry no information; the count alone defines the header
   assign unused_keep_insert = ^keep_insert;

   function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   // MSB-justified byte-enable mask with n ones (n in 0..W)
   function automatic logic [W-1:0] keep_mask(input logic [CW-1:0] n);
      logic [W-1:0] m;
      m = '0;
      for (int i = 0; i < W; i++) m[W-1-i] = (CW'(i) < n);
      return m;
   endfunction

   // Zero payload bytes whose keep bit is clear so partial beats leave zeros behind
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_mask
         assign payload_masked[8*gi +: 8] = keep_in[gi] ? data_in[8*gi +: 8] : 8'h00;
      end
   endgenerate

   assign out_free     = !valid_q || ready_out;
   assign ready_insert = (state_q == IDLE);
   assign ready_in     = (state_q == BODY) && out_free;

   assign valid_out = valid_q;
   assign data_out  = data_q;
   assign keep_out  = keep_q;
   assign last_out  = last_q;

   // Merge residual and incoming payload into one 2W-byte window
   always_comb begin
      hdr_n  = (CW'(hdr_byte_cnt) > CW'(W)) ? CW'(W) : CW'(hdr_byte_cnt);
      k_cnt  = popcnt(keep_in);
      t_cnt  = r_q + k_cnt;
      merged = {res_q, {DATA_WD{1'b0}}} | ({payload_masked, {DATA_WD{1'b0}}} >> (8 * r_q));
   end

   // Next-state and output-register logic
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      r_d     = r_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q && !ready_out;

      case (state_q)
         IDLE: begin
            // Output register may still hold the previous last beat; headers are taken anyway
            if (valid_insert) begin
               res_d   = data_insert << (8 * (CW'(W) - hdr_n));
               r_d     = hdr_n;
               state_d = BODY;
            end
         end
         BODY: begin
            if (valid_in && out_free) begin
               valid_d = 1'b1;
               data_d  = merged[2*DATA_WD-1:DATA_WD];
               keep_d  = keep_mask((t_cnt > CW'(W)) ? CW'(W) : t_cnt);
               last_d  = 1'b0;
               if (t_cnt > CW'(W)) begin
                  res_d = merged[DATA_WD-1:0];
                  r_d   = t_cnt - CW'(W);
               end else begin
                  res_d = '0;
                  r_d   = '0;
               end
               if (last_in) begin
                  if (t_cnt > CW'(W)) begin
                     state_d = FLUSH;
                  end else begin
                     last_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               valid_d = 1'b1;
               data_d  = res_q;
               keep_d  = keep_mask(r_q);
               last_d  = 1'b1;
               res_d   = '0;
               r_d     = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            res_d   = '0;
            r_d     = '0;
         end
      endcase
   end

   // State, residual and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         res_q   <= '0;
         r_q     <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         r_q     <= r_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

`ifdef AXIS_HDR_STATS_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;

   // Count packets as their last beat is accepted downstream (wraps naturally)
   always_comb begin
      pkt_cnt_d = pkt_cnt_q + ((valid_q && ready_out && last_q) ? 16'd1 : 16'd0);
   end

   // Packet counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pkt_cnt_q <= '0;
      else        pkt_cnt_q <= pkt_cnt_d;
   end

   assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_header_insert_stream.sv
// Testbench for axis_header_insert_stream (W=4). A byte-queue model builds the
// expected output beats per packet; a monitor compares every accepted beat.
module tb_axis_header_insert_stream;

   localparam int DW    = 32;
   localparam int W     = 4;
   localparam int CNTW  = 3;
   localparam int BOUND = 1000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            valid_in = 1'b0;
   logic            ready_in;
   logic [DW-1:0]   data_in = '0;
   logic [W-1:0]    keep_in = '0;
   logic            last_in = 1'b0;
   logic            valid_out;
   logic            ready_out = 1'b0;
   logic [DW-1:0]   data_out;
   logic [W-1:0]    keep_out;
   logic            last_out;
   logic            valid_insert = 1'b0;
   logic            ready_insert;
   logic [DW-1:0]   data_insert = '0;
   logic [W-1:0]    keep_insert = '0;
   logic [CNTW-1:0] hdr_byte_cnt = '0;
`ifdef AXIS_HDR_STATS_EN
   logic [15:0]     pkt_cnt;
`endif

   typedef struct packed {
      logic [DW-1:0] d;
      logic [W-1:0]  k;
      logic          l;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] pkt_d[$];
   logic [W-1:0]  pkt_k[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            exp_pkts = 0;
   bit            mon_en = 1'b0;
   bit            rand_done = 1'b0;

   axis_header_insert_stream dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_in     (valid_in),
      .ready_in     (ready_in),
      .data_in      (data_in),
      .keep_in      (keep_in),
      .last_in      (last_in),
      .valid_out    (valid_out),
      .ready_out    (ready_out),
      .data_out     (data_out),
      .keep_out     (keep_out),
      .last_out     (last_out),
      .valid_insert (valid_insert),
      .ready_insert (ready_insert),
      .data_insert  (data_insert),
      .keep_insert  (keep_insert),
      .hdr_byte_cnt (hdr_byte_cnt)
`ifdef AXIS_HDR_STATS_EN
      ,
      .pkt_cnt      (pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Expected output = header bytes followed by payload bytes, cut into W-byte beats
   function automatic void model_push(input logic [DW-1:0] hdr, input int n);
      logic [7:0]    bytes[$];
      logic [DW-1:0] word;
      logic [W-1:0]  kv;
      beat_t         b;
      int            nc;
      int            kc;
      nc = (n > W) ? W : n;
      for (int j = 0; j < nc; j++) bytes.push_back(hdr[8*(nc-1-j) +: 8]);
      for (int i = 0; i < pkt_d.size(); i++) begin
         word = pkt_d[i];
         kv   = (i == pkt_d.size() - 1) ? pkt_k[i] : 4'hF;
         kc   = $countones(kv);
         for (int j = 0; j < kc; j++) bytes.push_back(word[8*(W-1-j) +: 8]);
      end
      for (int s = 0; s < bytes.size(); s += W) begin
         b = '0;
         for (int j = 0; j < W; j++) begin
            if (s + j < bytes.size()) begin
               b.d[8*(W-1-j) +: 8] = bytes[s+j];
               b.k[W-1-j] = 1'b1;
            end
         end
         b.l = (s + W >= bytes.size());
         exp_q.push_back(b);
      end
   endfunction

   task automatic send_hdr(input logic [DW-1:0] hdr, input int n);
      int waits;
      waits = 0;
      valid_insert = 1'b1;
      data_insert  = hdr;
      hdr_byte_cnt = CNTW'(n);
      keep_insert  = W'($urandom);
      forever begin
         @(negedge clk);
         if (ready_insert) break;
         waits++;
         if (waits > BOUND) begin
            check("hdr_timeout", 64'(waits), 64'(BOUND));
            break;
         end
      end
      @(posedge clk);
      #1;
      valid_insert = 1'b0;
      data_insert  = $urandom;
      hdr_byte_cnt = '0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l,
                            output int waits);
      waits    = 0;
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      forever begin
         @(negedge clk);
         if (ready_in) break;
         waits++;
         if (waits > BOUND) begin
            check("in_timeout", 64'(waits), 64'(BOUND));
            break;
         end
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      data_in  = $urandom;
      keep_in  = '0;
      last_in  = 1'b0;
   endtask

   task automatic send_packet(input logic [DW-1:0] hdr, input int n, input bit gaps,
                              input bit chk_rate);
      int  waits;
      int  last_i;
      last_i = pkt_d.size() - 1;
      model_push(hdr, n);
      $display("pkt hdr=%08h n=%0d beats=%0d last_keep=%h", hdr, n, pkt_d.size(), pkt_k[last_i]);
      send_hdr(hdr, n);
      for (int i = 0; i <= last_i; i++) begin
         if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
         send_beat(pkt_d[i], (i == last_i) ? pkt_k[i] : 4'hF, i == last_i, waits);
         if (chk_rate) begin
            check("rate_waits", 64'(waits), 64'd0);
            check("lat_valid", 64'(valid_out), 64'd1);
            check("lat_data", 64'(data_out), 64'(pkt_d[i]));
         end
      end
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < BOUND) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      repeat (2) begin @(posedge clk); #1; end
      check("idle_valid", 64'(valid_out), 64'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_valid_out", 64'(valid_out), 64'd0);
      check("rst_data_out", 64'(data_out), 64'd0);
      check("rst_keep_out", 64'(keep_out), 64'd0);
      check("rst_last_out", 64'(last_out), 64'd0);
      check("rst_ready_insert", 64'(ready_insert), 64'd1);
      check("rst_ready_in", 64'(ready_in), 64'd0);
   endtask

   // Output monitor: compare accepted beats and check stability under backpressure
   initial begin
      beat_t         e;
      bit            prev_stall;
      logic [DW+W+1:0] prev_vec;
      prev_stall = 1'b0;
      prev_vec   = '0;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check("stall_hold", 64'({valid_out, last_out, keep_out, data_out}), 64'(prev_vec));
            if (valid_out && ready_out) begin
               check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("out_data", 64'(data_out), 64'(e.d));
                  check("out_keep", 64'(keep_out), 64'(e.k));
                  check("out_last", 64'(last_out), 64'(e.l));
                  if (e.l) exp_pkts++;
               end
            end
            prev_stall = valid_out && !ready_out;
            prev_vec   = {valid_out, last_out, keep_out, data_out};
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int waits;
      int nb;
      int kk;
      // reset state
      rst_n     = 1'b0;
      ready_out = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // 2-byte header, FLUSH path, with 3 cycles of output backpressure mid-packet
      pkt_d = '{32'h11223344, 32'h55667788};
      pkt_k = '{4'hF, 4'hF};
      model_push(32'h0000AABB, 2);
      $display("pkt hdr=0000aabb n=2 beats=2 stalled");
      send_hdr(32'h0000AABB, 2);
      send_beat(32'h11223344, 4'hF, 1'b0, waits);
      ready_out = 1'b0;
      fork
         send_beat(32'h55667788, 4'hF, 1'b1, waits);
         begin
            repeat (3) begin
               @(negedge clk);
               check("stall_ready_in", 64'(ready_in), 64'd0);
            end
            @(posedge clk);
            #1;
            ready_out = 1'b1;
         end
      join
      wait_drain();
`ifdef AXIS_HDR_STATS_EN
      check("pkt_cnt_one", 64'(pkt_cnt), 64'd1);
`endif

      // same packet unstalled, then back-to-back short packets
      send_packet(32'h0000AABB, 2, 1'b0, 1'b0);
      pkt_d = '{32'h11ABCDEF};
      pkt_k = '{4'h8};
      send_packet(32'h00CCDDEE, 3, 1'b0, 1'b0);
      pkt_d = '{32'hA0A1A2A3};
      pkt_k = '{4'hE};
      send_packet(32'h01020304, 4, 1'b0, 1'b0);
      // header count above W clamps to W
      send_packet(32'h01020304, 7, 1'b0, 1'b0);
      wait_drain();

      // no header: pass-through, one-cycle latency, one beat per cycle
      pkt_d = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
      pkt_k = '{4'hF, 4'hF, 4'hF};
      send_packet(32'hFFFFFFFF, 0, 1'b0, 1'b1);
      wait_drain();

      // reset in BODY after one beat
      mon_en    = 1'b0;
      ready_out = 1'b0;
      $display("pkt hdr=0000aabb n=2 interrupted by reset");
      send_hdr(32'h0000AABB, 2);
      send_beat(32'h11223344, 4'hF, 1'b0, waits);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      exp_q.delete();
      exp_pkts  = 0;
      ready_out = 1'b1;
      mon_en    = 1'b1;
      pkt_d = '{32'h11223344, 32'h55667788};
      pkt_k = '{4'hF, 4'hF};
      send_packet(32'h0000AABB, 2, 1'b0, 1'b0);
      wait_drain();

      // randomized packets with random backpressure and input gaps
      rand_done = 1'b0;
      fork
         begin
            for (int p = 0; p < 150; p++) begin
               pkt_d.delete();
               pkt_k.delete();
               nb = $urandom_range(1, 5);
               for (int i = 0; i < nb; i++) begin
                  pkt_d.push_back($urandom);
                  kk = (i == nb - 1) ? $urandom_range(1, W) : W;
                  pkt_k.push_back(W'(4'hF << (W - kk)));
               end
               send_packet($urandom, $urandom_range(0, 7), 1'b1, 1'b0);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               ready_out = ($urandom_range(0, 3) != 0);
            end
         end
      join
      ready_out = 1'b1;
      wait_drain();
`ifdef AXIS_HDR_STATS_EN
      check("pkt_cnt_final", 64'(pkt_cnt), 64'(exp_pkts[15:0]));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
